// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter
// Shares one unsigned (WIDTH+1)-bit adder among NUM_REQ requesters. A
// round-robin arbiter picks one request in IDLE and captures its operands.
// The block adds them in EXEC and holds the tagged result in RESP until the
// consumer takes it.
// Optional feature: define ADDER_ARB_SAT_EN to saturate the sum to all-ones
// when the add carries out. rsp_cout still reports the carry.
module adder_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0]       req_cin,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic                     rsp_cout,
    output logic [ID_W-1:0]          rsp_id
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [ID_W:0]   NUM_REQ_W = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);

    state_t             state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               cin_q, cin_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]   rsp_sum_q, rsp_sum_d;
    logic               rsp_cout_q, rsp_cout_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;

    logic               grant_found_s;
    logic [ID_W-1:0]    grant_idx_s;
    logic [ID_W:0]      cand_s;
    logic [WIDTH-1:0]   a_sel_s;
    logic [WIDTH-1:0]   b_sel_s;
    logic               cin_sel_s;
    logic [NUM_REQ-1:0] req_ready_s;
    logic [WIDTH:0]     sum_ext_s;
    logic [WIDTH-1:0]   sum_res_s;

    // Round-robin search: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = {ID_W{1'b0}};
        cand_s        = {(ID_W+1){1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_s = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (cand_s >= NUM_REQ_W) begin
                cand_s = cand_s - NUM_REQ_W;
            end else begin
                cand_s = cand_s;
            end
            if (!grant_found_s && req_valid[cand_s[ID_W-1:0]]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = cand_s[ID_W-1:0];
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Operand mux for the granted requester (AND-OR over all lanes).
    always_comb begin
        a_sel_s   = {WIDTH{1'b0}};
        b_sel_s   = {WIDTH{1'b0}};
        cin_sel_s = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            a_sel_s   = a_sel_s | (req_a[i*WIDTH +: WIDTH] & {WIDTH{ID_W'(i) == grant_idx_s}});
            b_sel_s   = b_sel_s | (req_b[i*WIDTH +: WIDTH] & {WIDTH{ID_W'(i) == grant_idx_s}});
            cin_sel_s = cin_sel_s | (req_cin[i] & (ID_W'(i) == grant_idx_s));
        end
    end

    // Shared adder: zero-extended unsigned add, carry lands in the top bit.
    assign sum_ext_s = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};

`ifdef ADDER_ARB_SAT_EN
    assign sum_res_s = sum_ext_s[WIDTH] ? {WIDTH{1'b1}} : sum_ext_s[WIDTH-1:0];
`else
    assign sum_res_s = sum_ext_s[WIDTH-1:0];
`endif

    // Next-state, capture and response logic for the IDLE/EXEC/RESP sequence.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        a_d         = a_q;
        b_d         = b_q;
        cin_d       = cin_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_cout_d  = rsp_cout_q;
        rsp_id_d    = rsp_id_q;
        req_ready_s = {NUM_REQ{1'b0}};
        case (state_q)
            ST_IDLE: begin
                if (grant_found_s) begin
                    req_ready_s[grant_idx_s] = 1'b1;
                    a_d     = a_sel_s;
                    b_d     = b_sel_s;
                    cin_d   = cin_sel_s;
                    id_d    = grant_idx_s;
                    state_d = ST_EXEC;
                    if (grant_idx_s == LAST_ID) begin
                        rr_ptr_d = {ID_W{1'b0}};
                    end else begin
                        rr_ptr_d = grant_idx_s + ID_W'(1'b1);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                rsp_sum_d   = sum_res_s;
                rsp_cout_d  = sum_ext_s[WIDTH];
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d     = ST_RESP;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= {ID_W{1'b0}};
            a_q         <= {WIDTH{1'b0}};
            b_q         <= {WIDTH{1'b0}};
            cin_q       <= 1'b0;
            id_q        <= {ID_W{1'b0}};
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= {WIDTH{1'b0}};
            rsp_cout_q  <= 1'b0;
            rsp_id_q    <= {ID_W{1'b0}};
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cin_q       <= cin_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_cout_q  <= rsp_cout_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    // req_ready is forced low while reset is held so nothing is accepted.
    assign req_ready = req_ready_s & {NUM_REQ{rst_n}};
    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Self-checking bench for adder_share_arbiter: directed steps plus a randomized
// phase, checked against a plain-arithmetic reference model.
module tb_adder_share_arbiter;

    localparam int N = 4;
    localparam int W = 32;
    localparam int IW = 2;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_cin;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [W-1:0]   rsp_sum;
    logic           rsp_cout;
    logic [IW-1:0]  rsp_id;

    adder_share_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_id    (rsp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Requester-side state and reference model
    bit [N-1:0]  pending;
    logic [31:0] op_a [N];
    logic [31:0] op_b [N];
    bit          op_cin [N];
    int          m_ptr;
    int          last_accept;

    int checks_total  = 0;
    int checks_passed = 0;
    int checks_failed = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else begin
            checks_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        req_valid = pending;
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = op_a[i];
            req_b[i*W +: W] = op_b[i];
            req_cin[i]      = op_cin[i];
        end
    endtask

    task automatic new_op(input int i);
        op_a[i]   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
        op_b[i]   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
        op_cin[i] = 1'($urandom_range(0, 1));
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input bit c);
        op_a[i] = a; op_b[i] = b; op_cin[i] = c; pending[i] = 1'b1;
    endtask

    // First pending requester at or after the model pointer, wrapping.
    function automatic int model_pick();
        for (int k = 0; k < N; k++) begin
            if (pending[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return 0;
    endfunction

    // One full transaction from IDLE: grant, EXEC, RESP (optionally stalled), handshake.
    task automatic serve_one(input int delay, input bit keep, input bit chk_gap, output int g);
        longint unsigned total;
        logic [31:0]     e_sum;
        logic            e_cout;
        #1;
        g = model_pick();
        check("req_ready_grant", 64'(req_ready), 64'(1 << g));
        total  = longint'(op_a[g]) + longint'(op_b[g]) + longint'(op_cin[g]);
        e_cout = total >= 64'h1_0000_0000;
        e_sum  = total[31:0];
`ifdef ADDER_ARB_SAT_EN
        if (e_cout) e_sum = 32'hFFFF_FFFF;
`endif
        @(posedge clk);
        #1;
        if (chk_gap) check("accept_gap", 64'(cyc - last_accept), 64'd3);
        last_accept = cyc;
        m_ptr = (g + 1) % N;
        if (keep) new_op(g);
        else pending[g] = 1'b0;
        drive();
        if (delay > 0) rsp_ready = 1'b0;
        #1;
        check("exec_req_ready", 64'(req_ready), 64'd0);
        check("exec_rsp_valid", 64'(rsp_valid), 64'd0);
        @(posedge clk);
        #1;
        check("rsp_valid", 64'(rsp_valid), 64'd1);
        check("rsp_sum", 64'(rsp_sum), 64'(e_sum));
        check("rsp_cout", 64'(rsp_cout), 64'(e_cout));
        check("rsp_id", 64'(rsp_id), 64'(g));
        check("resp_req_ready", 64'(req_ready), 64'd0);
        for (int d = 0; d < delay; d++) begin
            @(posedge clk);
            #1;
            check("stall_valid", 64'(rsp_valid), 64'd1);
            check("stall_sum", 64'(rsp_sum), 64'(e_sum));
            check("stall_id", 64'(rsp_id), 64'(g));
            check("stall_req_ready", 64'(req_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("rsp_consumed", 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        int g;
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        pending   = '0;
        m_ptr     = 0;
        last_accept = 0;
        for (int i = 0; i < N; i++) begin
            new_op(i);
            pending[i] = 1'b1;
        end
        drive();

        // Reset held two cycles with every request valid
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_sum", 64'(rsp_sum), 64'd0);
        check("rst_rsp_cout", 64'(rsp_cout), 64'd0);
        check("rst_rsp_id", 64'(rsp_id), 64'd0);
        rst_n = 1'b1;
        m_ptr = 0;

        // Round-robin with all requesters continuously valid: 0,1,2,3,0
        serve_one(0, 1'b1, 1'b0, g);
        check("first_grant", 64'(g), 64'd0);
        for (int r = 0; r < 4; r++) serve_one(0, 1'b1, 1'b1, g);
        // Drain remaining requests: 1,2,3,0
        for (int r = 0; r < 4; r++) serve_one(0, 1'b0, 1'b1, g);

        // Single add on requester 2
        set_op(2, 32'h0000_0005, 32'h0000_0003, 1'b1);
        drive();
        serve_one(0, 1'b0, 1'b0, g);
        // Overflow on requester 1
        set_op(1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        drive();
        serve_one(0, 1'b0, 1'b0, g);
        // Max operands plus carry-in on requester 3
        set_op(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        drive();
        serve_one(0, 1'b0, 1'b0, g);
        // Backpressure: five stalled cycles on requester 0
        new_op(0);
        pending[0] = 1'b1;
        drive();
        serve_one(5, 1'b0, 1'b0, g);

        // Reset during EXEC: result discarded, pointer back to 0
        new_op(1);
        pending[1] = 1'b1;
        drive();
        #1;
        check("mid_grant", 64'(req_ready), 64'b0010);
        @(posedge clk);
        #1;
        new_op(3);
        pending[3] = 1'b1;
        rst_n = 1'b0;
        drive();
        #1;
        check("mid_rst_req_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        check("mid_rst_valid", 64'(rsp_valid), 64'd0);
        check("mid_rst_sum", 64'(rsp_sum), 64'd0);
        check("mid_rst_id", 64'(rsp_id), 64'd0);
        @(posedge clk);
        #1;
        check("mid_rst_valid2", 64'(rsp_valid), 64'd0);
        rst_n = 1'b1;
        m_ptr = 0;
        serve_one(0, 1'b0, 1'b0, g);
        check("regrant_after_rst", 64'(g), 64'd1);
        serve_one(0, 1'b0, 1'b0, g);

        // Randomized phase
        for (int it = 0; it < 24; it++) begin
            for (int i = 0; i < N; i++) begin
                if (!pending[i] && $urandom_range(0, 1) == 1) begin
                    new_op(i);
                    pending[i] = 1'b1;
                end
            end
            if (pending == '0) begin
                new_op(it % N);
                pending[it % N] = 1'b1;
            end
            drive();
            serve_one($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0, g);
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
